quesadilla_fetch_ctrl: RTL and testbench
========================================

// Module: quesadilla_fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer for the Quesadilla datapath. Owns the PC, drives
//   instruction-memory requests over a req/ack handshake, and presents each fetched
//   word on InstQ with a valid/ready handshake. Applies branch redirects and flags
//   memory timeouts. Sits between instruction memory and the decode stage.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded at reset; first fetch address after START
//   TIMEOUT    16             cycles in FETCH without IMEM_ACK before error (2..255)
//   HALT_WORD  32'hFFFF_FFFF  opcode treated as halt (QUESADILLA_HALT_EN only)
// PORTS
//   CLK_Q       in   1   clock, all state on rising edge
//   RSTN_Q      in   1   synchronous reset, active-low
//   START       in   1   begin fetching from the current PC (honoured in IDLE only)
//   IMEM_REQ    out  1   fetch request, held until IMEM_ACK or timeout
//   IMEM_ADDR   out  32  fetch address = PC, stable while IMEM_REQ=1
//   IMEM_ACK    in   1   IMEM_RDATA valid this cycle; completes request
//   IMEM_RDATA  in   32  instruction word
//   InstQ       out  32  captured instruction
//   PC_Q        out  32  address InstQ was fetched from
//   INST_VALID  out  1   InstQ/PC_Q valid
//   INST_READY  in   1   decode accepts InstQ
//   BR_TAKEN    in   1   redirect; sampled only on handshake cycle
//   BR_TARGET   in   32  redirect address
//   BUSY        out  1   state != IDLE (and != HALT)
//   ERR_Q       out  1   sticky timeout flag
//   HALTED      out  1   halt reached
// BEHAVIOUR
//   - Reset (RSTN_Q=0 at edge): state=IDLE, PC=RESET_PC, IMEM_REQ=0, InstQ=0, PC_Q=0,
//     INST_VALID=0, ERR_Q=0, HALTED=0, timeout counter=0. Mid-operation reset aborts
//     any outstanding request; an IMEM_ACK in the reset cycle is discarded.
//   - States: IDLE, FETCH, OUT, HALT.
//   - IDLE: START=1 -> FETCH next cycle. START in any other state ignored.
//   - FETCH: IMEM_REQ=1, IMEM_ADDR=PC. Counter clears on entry, +1 per cycle.
//     IMEM_ACK=1 -> next edge: InstQ<=IMEM_RDATA, PC_Q<=PC, INST_VALID<=1,
//     PC<=PC+4 (mod 2^32, FFFF_FFFC wraps to 0), state OUT. Same-cycle ACK legal:
//     ACK to INST_VALID latency is 1 cycle.
//   - Timeout: counter==TIMEOUT-1 with no ACK -> ERR_Q<=1 (sticky to reset),
//     IMEM_REQ<=0, state IDLE, PC unchanged. ACK in that cycle wins: no error.
//   - OUT: InstQ/PC_Q held stable while INST_VALID=1 and INST_READY=0.
//     INST_VALID & INST_READY -> INST_VALID<=0, state FETCH; if BR_TAKEN also 1,
//     PC<={BR_TARGET[31:2],2'b00} (low bits forced zero, no error).
//   - BR_TAKEN outside the handshake cycle has no effect.
//   - Peak throughput: one instruction per 2 cycles (ack same cycle, ready held).
// CONFIGURATION
//   QUESADILLA_HALT_EN defined: on handshake of an InstQ equal to HALT_WORD, state
//     HALT instead of FETCH; no further requests, BUSY=0, HALTED=1 until reset;
//     START ignored in HALT.
//   Undefined: HALT_WORD fetched and handed off as a normal instruction; HALT state
//     absent; HALTED tied 0.
// TESTING
//   1. Reset, START, ACK same cycle as REQ, READY=1 -> IMEM_ADDR 0,4,8,...; InstQ
//      follows RDATA; INST_VALID rises 1 cycle after each ACK.
//   2. ACK delayed 3 cycles, READY low 4 cycles -> IMEM_ADDR stable 4 cycles;
//      InstQ/PC_Q unchanged while stalled; no extra requests issued.
//   3. Handshake with BR_TAKEN=1, BR_TARGET=32'h0000_0103 -> next IMEM_ADDR
//      32'h0000_0100; BR_TAKEN pulsed while INST_VALID=0 -> ignored.
//   4. No ACK, TIMEOUT=16 -> ERR_Q=1 after 16 FETCH cycles, IMEM_REQ=0, IDLE;
//      ACK on cycle 16 -> ERR_Q stays 0.
//   5. RESET_PC=32'hFFFF_FFFC -> second fetch at 32'h0; RSTN_Q low mid-FETCH with
//      ACK -> all outputs at reset values, INST_VALID stays 0.
//   6. QUESADILLA_HALT_EN, RDATA=HALT_WORD accepted -> HALTED=1, BUSY=0, no REQ,
//      START ignored; macro undefined -> fetching continues at next PC.

Source files
------------

// File: rtl/quesadilla_fetch_ctrl_if.sv
// quesadilla_fetch_ctrl_if: fetch-controller bundle covering the memory side, the decode side and status.
// master = the fetch controller, slave = the environment (memory, decode, control).
interface quesadilla_fetch_ctrl_if;
  logic        START;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic [31:0] InstQ;
  logic [31:0] PC_Q;
  logic        INST_VALID;
  logic        INST_READY;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        BUSY;
  logic        ERR_Q;
  logic        HALTED;
  modport master (
    input  START, IMEM_ACK, IMEM_RDATA, INST_READY, BR_TAKEN, BR_TARGET,
    output IMEM_REQ, IMEM_ADDR, InstQ, PC_Q, INST_VALID, BUSY, ERR_Q, HALTED
  );
  modport slave (
    output START, IMEM_ACK, IMEM_RDATA, INST_READY, BR_TAKEN, BR_TARGET,
    input  IMEM_REQ, IMEM_ADDR, InstQ, PC_Q, INST_VALID, BUSY, ERR_Q, HALTED
  );
endinterface

// File: rtl/quesadilla_fetch_ctrl.sv
// quesadilla_fetch_ctrl: instruction-fetch sequencer with branch redirect and memory timeout.
// Define QUESADILLA_HALT_EN to stop fetching after handing off HALT_WORD.
module quesadilla_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
`ifdef QUESADILLA_HALT_EN
  , parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
`endif
) (
  input logic CLK_Q,
  input logic RSTN_Q,
  quesadilla_fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, FETCH, OUT
`ifdef QUESADILLA_HALT_EN
    , HALT
`endif
  } state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t state, state_n, after_out;
  logic [31:0] pc, pc_n, inst, inst_n, pcq, pcq_n;
  logic valid, valid_n, err, err_n, handoff;
  logic [7:0] cnt, cnt_n;
  assign handoff = valid & bus.INST_READY;
`ifdef QUESADILLA_HALT_EN
  assign after_out  = inst == HALT_WORD ? HALT : FETCH;
  assign bus.HALTED = state == HALT;
`else
  assign after_out  = FETCH;
  assign bus.HALTED = 1'b0;
`endif
  always_ff @(posedge CLK_Q) state <= !RSTN_Q ? IDLE : state_n;
  always_ff @(posedge CLK_Q)
    if (!RSTN_Q) begin
      pc    <= RESET_PC;
      inst  <= '0;
      pcq   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      pc    <= pc_n;
      inst  <= inst_n;
      pcq   <= pcq_n;
      valid <= valid_n;
      err   <= err_n;
      cnt   <= cnt_n;
    end
  // the counter sits at zero outside FETCH so it always starts fresh on entry
  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = inst;
    pcq_n   = pcq;
    valid_n = valid;
    err_n   = err;
    cnt_n   = '0;
    case (state)
      IDLE: state_n = bus.START ? FETCH : IDLE;
      FETCH: begin
        cnt_n = cnt + 8'd1;
        if (bus.IMEM_ACK) begin
          state_n = OUT;
          inst_n  = bus.IMEM_RDATA;
          pcq_n   = pc;
          pc_n    = pc + 32'd4;
          valid_n = 1'b1;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      OUT:
        if (handoff) begin
          state_n = after_out;
          valid_n = 1'b0;
          pc_n    = bus.BR_TAKEN ? bus.BR_TARGET & ~32'h3 : pc;
        end
      default: state_n = state;
    endcase
  end
  assign bus.IMEM_REQ   = state == FETCH;
  assign bus.IMEM_ADDR  = pc;
  assign bus.InstQ      = inst;
  assign bus.PC_Q       = pcq;
  assign bus.INST_VALID = valid;
  assign bus.BUSY       = state == FETCH || state == OUT;
  assign bus.ERR_Q      = err;
endmodule

// File: tb/tb_quesadilla_fetch_ctrl.sv
// tb_quesadilla_fetch_ctrl: directed bench with a transaction-level reference model checked every cycle.
// The memory responder acks after a programmable number of request cycles; halt checks follow QUESADILLA_HALT_EN.
module tb_quesadilla_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam int          TMO    = 16;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
`ifdef QUESADILLA_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif
  logic CLK_Q = 1'b0;
  logic RSTN_Q = 1'b0;
  quesadilla_fetch_ctrl_if bus();
  quesadilla_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (.CLK_Q(CLK_Q), .RSTN_Q(RSTN_Q), .bus(bus));
  always #5 CLK_Q = ~CLK_Q;
  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int req_age = 0;
  int last_req_len = 0;
  logic [31:0] halt_addr = 32'h1;
  logic [31:0] addr_log[$];
  bit model_ok = 1'b0;
  bit m_fetching, m_valid, m_halted, m_err;
  int m_age;
  logic [31:0] m_pc, m_instq, m_pcq;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a == halt_addr ? HALT_W : {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return i < addr_log.size() ? addr_log[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // one clock, then the memory answers the request that is now visible
  task automatic tick();
    @(posedge CLK_Q);
    #1;
    if (bus.IMEM_REQ) begin
      bus.IMEM_ACK   = ack_delay >= 0 && req_age == ack_delay;
      bus.IMEM_RDATA = word_at(bus.IMEM_ADDR);
      if (bus.IMEM_ACK) addr_log.push_back(bus.IMEM_ADDR);
      req_age++;
    end else begin
      if (req_age != 0) last_req_len = req_age;
      req_age        = 0;
      bus.IMEM_ACK   = 1'b0;
      bus.IMEM_RDATA = 32'h0;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.INST_VALID && n < 60) begin
      tick();
      n++;
    end
    chk1("wait_valid_bound", bus.INST_VALID, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.BUSY && n < 60) begin
      tick();
      n++;
    end
    chk1("wait_idle_bound", bus.BUSY, 1'b0);
  endtask

  // reference model: a fetch is either outstanding, waiting for decode, halted, or nothing is happening
  always @(posedge CLK_Q) begin
    if (!RSTN_Q) begin
      model_ok = 1'b1;
      m_fetching = 1'b0;
      m_valid = 1'b0;
      m_halted = 1'b0;
      m_err = 1'b0;
      m_age = 0;
      m_pc = RST_PC;
      m_instq = 32'h0;
      m_pcq = 32'h0;
    end else if (m_fetching) begin
      if (bus.IMEM_ACK) begin
        m_fetching = 1'b0;
        m_valid = 1'b1;
        m_instq = bus.IMEM_RDATA;
        m_pcq = m_pc;
        m_pc = m_pc + 32'd4;
      end else if (m_age == TMO - 1) begin
        m_fetching = 1'b0;
        m_err = 1'b1;
      end else m_age++;
    end else if (m_valid) begin
      if (bus.INST_READY) begin
        m_valid = 1'b0;
        if (bus.BR_TAKEN) m_pc = {bus.BR_TARGET[31:2], 2'b00};
        if (HALT_ON && m_instq == HALT_W) m_halted = 1'b1;
        else begin
          m_fetching = 1'b1;
          m_age = 0;
        end
      end
    end else if (!m_halted && bus.START) begin
      m_fetching = 1'b1;
      m_age = 0;
    end
  end

  always @(negedge CLK_Q)
    if (model_ok) begin
      chk1("imem_req", bus.IMEM_REQ, m_fetching);
      if (m_fetching) chk("imem_addr", bus.IMEM_ADDR, m_pc);
      chk1("inst_valid", bus.INST_VALID, m_valid);
      chk("instq", bus.InstQ, m_instq);
      chk("pc_q", bus.PC_Q, m_pcq);
      chk1("busy", bus.BUSY, m_fetching | m_valid);
      chk1("err_q", bus.ERR_Q, m_err);
      chk1("halted", bus.HALTED, m_halted);
    end

  initial begin
    int n0;
    bit found;
    bus.START = 1'b0;
    bus.IMEM_ACK = 1'b0;
    bus.IMEM_RDATA = 32'h0;
    bus.INST_READY = 1'b0;
    bus.BR_TAKEN = 1'b0;
    bus.BR_TARGET = 32'h0;
    tick();
    tick();
    chk1("rst_req", bus.IMEM_REQ, 1'b0);
    chk1("rst_valid", bus.INST_VALID, 1'b0);
    chk("rst_instq", bus.InstQ, 32'h0);
    chk("rst_pcq", bus.PC_Q, 32'h0);
    chk1("rst_err", bus.ERR_Q, 1'b0);
    chk1("rst_busy", bus.BUSY, 1'b0);
    // back-to-back fetches, ack with the request, decode always ready
    RSTN_Q = 1'b1;
    bus.INST_READY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk1("t1_req", bus.IMEM_REQ, 1'b1);
    chk("t1_first_addr", bus.IMEM_ADDR, 32'hFFFF_FFFC);
    repeat (7) tick();
    chk("t1_log_n", 32'(addr_log.size()), 32'd4);
    chk("t1_log0", log_at(0), 32'hFFFF_FFFC);
    chk("t1_log1", log_at(1), 32'h0000_0000);
    chk("t1_log2", log_at(2), 32'h0000_0004);
    chk("t1_log3", log_at(3), 32'h0000_0008);
    chk("t1_pcq", bus.PC_Q, 32'h0000_0008);
    chk("t1_instq", bus.InstQ, 32'h5A52_0000);
    // decode stall, then a slow memory
    bus.INST_READY = 1'b0;
    wait_valid();
    ack_delay = 3;
    repeat (4) tick();
    chk("t2_hold_instq", bus.InstQ, 32'h5A52_0000);
    chk("t2_hold_pcq", bus.PC_Q, 32'h0000_0008);
    bus.INST_READY = 1'b1;
    tick();
    bus.INST_READY = 1'b0;
    wait_valid();
    chk("t2_req_len", 32'(last_req_len), 32'd4);
    chk("t2_pcq", bus.PC_Q, 32'h0000_000C);
    // branch on the handshake, then a branch pulse that must be ignored
    bus.BR_TAKEN = 1'b1;
    bus.BR_TARGET = 32'h0000_0103;
    bus.INST_READY = 1'b1;
    ack_delay = 0;
    tick();
    bus.BR_TAKEN = 1'b0;
    bus.INST_READY = 1'b0;
    chk("t3_br_addr", bus.IMEM_ADDR, 32'h0000_0100);
    bus.BR_TAKEN = 1'b1;
    bus.BR_TARGET = 32'h0000_0200;
    tick();
    bus.BR_TAKEN = 1'b0;
    chk("t3_pcq", bus.PC_Q, 32'h0000_0100);
    bus.INST_READY = 1'b1;
    tick();
    chk("t3_no_br_addr", bus.IMEM_ADDR, 32'h0000_0104);
    // ack on the last allowed cycle, then no ack at all
    ack_delay = TMO - 1;
    tick();
    tick();
    bus.INST_READY = 1'b0;
    wait_valid();
    chk("t4_late_len", 32'(last_req_len), 32'd16);
    chk1("t4_late_no_err", bus.ERR_Q, 1'b0);
    chk("t4_late_pcq", bus.PC_Q, 32'h0000_0108);
    ack_delay = -1;
    bus.INST_READY = 1'b1;
    wait_idle();
    chk1("t4_err", bus.ERR_Q, 1'b1);
    chk1("t4_req_off", bus.IMEM_REQ, 1'b0);
    chk("t4_tmo_len", 32'(last_req_len), 32'd16);
    // restart keeps the PC, then a reset lands on the ack cycle
    ack_delay = 0;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("t5_restart_addr", bus.IMEM_ADDR, 32'h0000_010C);
    chk1("t5_ack_seen", bus.IMEM_ACK, 1'b1);
    RSTN_Q = 1'b0;
    tick();
    chk1("t5_rst_valid", bus.INST_VALID, 1'b0);
    chk1("t5_rst_req", bus.IMEM_REQ, 1'b0);
    chk1("t5_rst_err", bus.ERR_Q, 1'b0);
    chk("t5_rst_instq", bus.InstQ, 32'h0);
    RSTN_Q = 1'b1;
    tick();
    chk1("t5_valid_low", bus.INST_VALID, 1'b0);
    // halt opcode at address 8
    halt_addr = 32'h0000_0008;
    n0 = addr_log.size();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("t5_wrap_first", bus.IMEM_ADDR, 32'hFFFF_FFFC);
    repeat (12) tick();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    repeat (3) tick();
    found = 1'b0;
    for (int i = n0; i < addr_log.size(); i++) if (addr_log[i] == 32'h0000_000C) found = 1'b1;
    chk("t5_wrap_second", log_at(n0 + 1), 32'h0000_0000);
`ifdef QUESADILLA_HALT_EN
    chk1("t6_halted", bus.HALTED, 1'b1);
    chk1("t6_busy", bus.BUSY, 1'b0);
    chk1("t6_req", bus.IMEM_REQ, 1'b0);
    chk1("t6_no_next_fetch", found, 1'b0);
`else
    chk1("t6_halted", bus.HALTED, 1'b0);
    chk1("t6_next_fetch", found, 1'b1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
